// File: rtl/l1_mem_bridge_if.sv
// rtl/l1_mem_bridge_if.sv - L1 request/response and memory command bus bundle
// The master modport is the bridge; the slave modport is the L1 plus memory side.
interface l1_mem_bridge_if;
  logic [26:0]  req_addr;
  logic [127:0] req_data;
  logic         req_rw;
  logic         req_valid;
  logic [127:0] resp_data;
  logic         resp_ready;
  logic         err_overflow;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  modport master (
    input  req_addr, req_data, req_rw, req_valid,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output resp_data, resp_ready, err_overflow,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output req_addr, req_data, req_rw, req_valid,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  resp_data, resp_ready, err_overflow,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/l1_mem_bridge.sv
// rtl/l1_mem_bridge.sv - L1 line fill / write-back bridge to a memory command port
// Requests land in a 2-entry FIFO and are serviced one at a time in arrival order.
module l1_mem_bridge (
  input  logic           sys_clk,
  input  logic           rstn,
  l1_mem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

  state_t        state, state_n;

  logic [23:0]   q_addr [2];
  logic [127:0]  q_data [2];
  logic          q_rw   [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic          push_ok, pop;

  logic [26:0]   app_addr_r;
  logic [2:0]    app_cmd_r;
  logic [127:0]  app_wdf_data_r;
  logic          cmd_pend, data_pend;
  logic          app_en_c, wren_c;
  logic [127:0]  resp_data_r;
  logic          resp_ready_r;
  logic          overflow_r;

  assign pop     = (state == IDLE) && (count != 2'd0) && bus.init_calib_complete;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = bus.req_valid && ((count != 2'd2) || pop);

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= bus.req_addr[26:3];
      q_data[wr_ptr] <= bus.req_data;
      q_rw[wr_ptr]   <= bus.req_rw;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (bus.req_valid && !push_ok) overflow_r <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    app_en_c = 1'b0;
    wren_c   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) state_n = q_rw[rd_ptr] ? WR_ISSUE : RD_ISSUE;
      end
      WR_ISSUE: begin
        app_en_c = cmd_pend;
        wren_c   = data_pend;
        // Command and data finish independently; leave once neither is outstanding.
        if ((!cmd_pend || bus.app_rdy) && (!data_pend || bus.app_wdf_rdy)) state_n = IDLE;
      end
      RD_ISSUE: begin
        app_en_c = 1'b1;
        if (bus.app_rdy) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.app_rd_data_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      app_addr_r     <= 27'd0;
      app_cmd_r      <= 3'd0;
      app_wdf_data_r <= 128'd0;
      cmd_pend       <= 1'b0;
      data_pend      <= 1'b0;
      resp_data_r    <= 128'd0;
      resp_ready_r   <= 1'b0;
    end else begin
      resp_ready_r <= 1'b0;
      if (pop) begin
        app_addr_r <= {q_addr[rd_ptr], 3'b000};
        app_cmd_r  <= q_rw[rd_ptr] ? 3'b000 : 3'b001;
        cmd_pend   <= q_rw[rd_ptr];
        data_pend  <= q_rw[rd_ptr];
        if (q_rw[rd_ptr]) app_wdf_data_r <= q_data[rd_ptr];
      end
      if (app_en_c && bus.app_rdy && (state == WR_ISSUE)) cmd_pend  <= 1'b0;
      if (wren_c && bus.app_wdf_rdy)                      data_pend <= 1'b0;
      if ((state == RD_WAIT) && bus.app_rd_data_valid) begin
        resp_data_r  <= bus.app_rd_data;
        resp_ready_r <= 1'b1;
      end
    end
  end

  assign bus.app_addr     = app_addr_r;
  assign bus.app_cmd      = app_cmd_r;
  assign bus.app_en       = app_en_c;
  assign bus.app_wdf_data = app_wdf_data_r;
  assign bus.app_wdf_wren = wren_c;
  assign bus.app_wdf_end  = wren_c;
  assign bus.resp_data    = resp_data_r;
  assign bus.resp_ready   = resp_ready_r;
  assign bus.err_overflow = overflow_r;

endmodule

// File: tb/tb_l1_mem_bridge.sv
// tb/tb_l1_mem_bridge.sv - scoreboard bench for l1_mem_bridge
// Expected commands, write data and read lines are queued at stimulus time.
`timescale 1ns/1ps
module tb_l1_mem_bridge;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  l1_mem_bridge_if bus ();

  l1_mem_bridge dut (
    .sys_clk (clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [29:0]  exp_cmd_q [$];
  logic [127:0] exp_wd_q  [$];
  logic [127:0] exp_rsp_q [$];

  int          cmd_cnt = 0;
  int          resp_cnt = 0;
  int          rd_en_cycles = 0;
  int          mem_cnt = 0;
  logic [26:0] mem_addr = 27'd0;
  logic        inject_valid;

  function automatic logic [127:0] line_of(input logic [26:0] a);
    return {32'hDEADBEEF, {5'b0, a}, 64'h0123_4567_89AB_CDEF ^ {37'b0, a}};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic rw, input logic [26:0] a, input logic [127:0] d, input bit acc);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_data  = d;
    if (acc) begin
      exp_cmd_q.push_back({a[26:3], 3'b000, (rw ? 3'b000 : 3'b001)});
      if (rw) exp_wd_q.push_back(d);
      else    exp_rsp_q.push_back(line_of({a[26:3], 3'b000}));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_resp(input int target, input int budget);
    for (int i = 0; i < budget && resp_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    check("resp_timeout", resp_cnt >= target, 1'b1);
  endtask

  task automatic wait_en(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.app_en; i++) begin
      @(posedge clk); #1;
    end
    check(tag, bus.app_en, 1'b1);
  endtask

  task automatic monitor();
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_cmd_q.delete();
        exp_wd_q.delete();
        exp_rsp_q.delete();
        mem_cnt = 0;
        bus.app_rd_data_valid = 1'b0;
      end else begin
        bus.app_rd_data_valid = inject_valid;
        if (inject_valid) bus.app_rd_data = line_of(mem_addr);
        if (mem_cnt != 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            bus.app_rd_data_valid = 1'b1;
            bus.app_rd_data       = line_of(mem_addr);
          end
        end
        if (bus.app_en && bus.app_cmd == 3'b001) rd_en_cycles++;
        if (bus.app_en && bus.app_rdy) begin
          cmd_cnt++;
          if (exp_cmd_q.size() == 0) check("cmd_unexpected", bus.app_en, 1'b0);
          else begin
            e = exp_cmd_q.pop_front();
            check("app_addr", bus.app_addr, e[29:3]);
            check("app_cmd", bus.app_cmd, e[2:0]);
            if (bus.app_cmd == 3'b001) begin
              mem_cnt  = 5;
              mem_addr = bus.app_addr;
            end
          end
        end
        if (bus.app_wdf_wren) check("wdf_end", bus.app_wdf_end, 1'b1);
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
          if (exp_wd_q.size() == 0) check("wdata_unexpected", bus.app_wdf_wren, 1'b0);
          else check("app_wdf_data", bus.app_wdf_data, exp_wd_q.pop_front());
        end
        if (bus.resp_ready) begin
          resp_cnt++;
          if (exp_rsp_q.size() == 0) check("resp_unexpected", bus.resp_ready, 1'b0);
          else check("resp_data", bus.resp_data, exp_rsp_q.pop_front());
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_resp_ready"}, bus.resp_ready, 1'b0);
    check({pfx, "_err_overflow"}, bus.err_overflow, 1'b0);
    check({pfx, "_app_en"}, bus.app_en, 1'b0);
    check({pfx, "_wdf_wren"}, bus.app_wdf_wren, 1'b0);
    check({pfx, "_wdf_end"}, bus.app_wdf_end, 1'b0);
    check({pfx, "_resp_data"}, bus.resp_data, 128'd0);
    check({pfx, "_app_addr"}, bus.app_addr, 27'd0);
    check({pfx, "_app_cmd"}, bus.app_cmd, 3'd0);
    check({pfx, "_wdf_data"}, bus.app_wdf_data, 128'd0);
  endtask

  initial begin
    int r0, c0, e0;
    time t0;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus.init_calib_complete = 1'b0; bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
    inject_valid = 1'b0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    idle(2);

    // Clean miss
    bus.init_calib_complete = 1'b1; bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    r0 = resp_cnt; e0 = rd_en_cycles; t0 = $time;
    drive_req(1'b0, 27'h0001238, 128'd0, 1'b1);
    wait_resp(r0 + 1, 60);
    check("miss_latency_ge3", (($time - t0) / 10) >= 3, 1'b1);
    check("miss_rd_en_cycles", rd_en_cycles - e0, 1);
    idle(3);

    // Dirty miss back-to-back
    r0 = resp_cnt; c0 = cmd_cnt;
    drive_req(1'b1, 27'h00A0008, {4{32'h1234_5678}}, 1'b1);
    drive_req(1'b0, 27'h00B0008, 128'd0, 1'b1);
    wait_resp(r0 + 1, 80);
    idle(10);
    check("dirty_resp_count", resp_cnt - r0, 1);
    check("dirty_cmd_count", cmd_cnt - c0, 2);

    // Split write handshake, unaligned address
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    drive_req(1'b1, 27'h0000C0F, {4{32'hA5A5_0F0F}}, 1'b1);
    wait_en("split_en_seen", 10);
    check("split_wren_before", bus.app_wdf_wren, 1'b1);
    bus.app_wdf_rdy = 1'b1;
    idle(1);
    bus.app_wdf_rdy = 1'b0;
    check("split_wren_dropped", bus.app_wdf_wren, 1'b0);
    check("split_en_held1", bus.app_en, 1'b1);
    idle(1);
    check("split_en_held2", bus.app_en, 1'b1);
    bus.app_rdy = 1'b1;
    idle(1);
    check("split_en_dropped", bus.app_en, 1'b0);
    check("split_wren_idle", bus.app_wdf_wren, 1'b0);
    bus.app_wdf_rdy = 1'b1;
    r0 = resp_cnt;
    drive_req(1'b0, 27'h0000C10, 128'd0, 1'b1);
    wait_resp(r0 + 1, 60);
    idle(3);

    // Overflow while uncalibrated
    bus.init_calib_complete = 1'b0;
    r0 = resp_cnt; c0 = cmd_cnt;
    check("ovf_clear_initially", bus.err_overflow, 1'b0);
    drive_req(1'b1, 27'h0100000, {4{32'hCAFE_F00D}}, 1'b1);
    drive_req(1'b0, 27'h0200010, 128'd0, 1'b1);
    check("ovf_not_yet", bus.err_overflow, 1'b0);
    drive_req(1'b0, 27'h0300000, 128'd0, 1'b0);
    check("ovf_set", bus.err_overflow, 1'b1);
    idle(5);
    check("ovf_no_cmd_uncal", cmd_cnt - c0, 0);
    bus.init_calib_complete = 1'b1;
    wait_resp(r0 + 1, 80);
    idle(10);
    check("ovf_cmd_count", cmd_cnt - c0, 2);
    check("ovf_resp_count", resp_cnt - r0, 1);
    check("ovf_sticky", bus.err_overflow, 1'b1);

    // Push while full in the same cycle as a pop
    bus.init_calib_complete = 1'b0;
    r0 = resp_cnt;
    drive_req(1'b0, 27'h0500008, 128'd0, 1'b1);
    drive_req(1'b0, 27'h0600010, 128'd0, 1'b1);
    bus.init_calib_complete = 1'b1;
    drive_req(1'b0, 27'h0700018, 128'd0, 1'b1);
    wait_resp(r0 + 3, 150);
    check("fullpp_resp_count", resp_cnt - r0, 3);
    idle(3);

    // Reset during RD_WAIT
    r0 = resp_cnt;
    drive_req(1'b0, 27'h0400000, 128'd0, 1'b1);
    wait_en("rstrd_en_seen", 10);
    idle(2);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rstrd");
    @(posedge clk); #1;
    rstn = 1'b1;
    inject_valid = 1'b1;
    idle(1);
    inject_valid = 1'b0;
    idle(8);
    check("rstrd_no_resp", resp_cnt - r0, 0);
    check("rstrd_resp_ready_low", bus.resp_ready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_bridge.md
L1_MEM_BRIDGE -- requirements
Module: l1_mem_bridge

Interface
REQ-001 Parameters: none; line width 128 bits, request address 27 bits, request queue depth 2, all fixed.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 sys_clk  input  1  rising-edge clock for all state.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 req_addr  input  27  line address from L1; bits [2:0] are ignored.
REQ-006 req_data  input  128  write-back line data; used only when req_rw=1.
REQ-007 req_rw  input  1  0 = line read (allocate), 1 = line write-back.
REQ-008 req_valid  input  1  single-cycle request pulse; sampled every cycle.
REQ-009 resp_data  output  128  read line returned to L1.
REQ-010 resp_ready  output  1  one-cycle pulse; resp_data is valid in that cycle.
REQ-011 err_overflow  output  1  sticky flag: a request was dropped because the queue was full.
REQ-012 init_calib_complete  input  1  memory ready; no command is issued while this is 0.
REQ-013 app_addr  output  27  memory command address, equal to {addr[26:3],3'b000}.
REQ-014 app_cmd  output  3  3'b000 = write, 3'b001 = read.
REQ-015 app_en  output  1  command valid; held until accepted.
REQ-016 app_rdy  input  1  command accepted in any cycle where app_en=1 and app_rdy=1.
REQ-017 app_wdf_data  output  128  write data.
REQ-018 app_wdf_wren, app_wdf_end  output  1 each  write-data valid and last beat; always driven equal.
REQ-019 app_wdf_rdy  input  1  write data accepted in any cycle where app_wdf_wren=1 and app_wdf_rdy=1.
REQ-020 app_rd_data  input  128  read data.
REQ-021 app_rd_data_valid  input  1  app_rd_data is valid this cycle (single beat).

Function
REQ-022 Every cycle with req_valid=1 pushes {addr, data, rw} into a 2-entry FIFO. No backpressure exists toward L1.
REQ-023 A push while the FIFO is full is discarded, sets err_overflow=1, and leaves the FIFO unchanged.
REQ-024 A push and a pop in the same cycle are both honoured, including when the FIFO is full, so the count is unchanged.
REQ-025 The FIFO read/write pointers wrap modulo 2. Entries are serviced strictly in arrival order, so a write-back always completes before a following read.
REQ-026 FSM states:
- IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
REQ-027 IDLE transitions:
- If the FIFO is non-empty and init_calib_complete=1: pop the head into working registers.
- Go to WR_ISSUE if rw=1, else RD_ISSUE.
- Otherwise stay in IDLE.
REQ-028 WR_ISSUE:
- Drive app_en=1, app_cmd=000, app_wdf_wren=app_wdf_end=1.
- Each of the command and the data deasserts independently in the cycle after its own handshake.
- Leave for IDLE in the cycle after both handshakes have occurred, in either order or together.
REQ-029 RD_ISSUE: drive app_en=1, app_cmd=001; on app_rdy=1 go to RD_WAIT.
REQ-030 RD_WAIT:
- On app_rd_data_valid=1, register app_rd_data into resp_data.
- Pulse resp_ready=1 for exactly one cycle, the cycle after app_rd_data_valid.
- Return to IDLE.
REQ-031 Read latency: resp_ready occurs no earlier than 3 cycles after req_valid (push, pop, issue, return), plus memory stalls.
REQ-032 resp_data holds its value until the next read completes. Write-backs never pulse resp_ready.
REQ-033 app_addr, app_cmd and app_wdf_data are stable while the corresponding enable is high and not yet accepted.
REQ-034 app_rd_data_valid outside RD_WAIT is ignored.
REQ-035 A FIFO pop occurs only in IDLE, at most one per cycle.

Reset
REQ-036 While rstn=0:
- FSM=IDLE, FIFO empty, pointers 0.
- app_en=0, app_wdf_wren=0, app_wdf_end=0, resp_ready=0, err_overflow=0.
- resp_data=0, app_addr=0, app_cmd=0, app_wdf_data=0.
REQ-037 Reset asserted mid-transaction abandons the in-flight command and all queued entries immediately. No resp_ready is produced for them.
REQ-038 err_overflow is cleared only by reset.

Verification
REQ-039 Clean miss:
- Stimulus: calib=1; req_valid pulse, rw=0, addr=0x0001238; app_rdy=1.
- Memory model returns 0xDEADBEEF_... after 5 cycles.
- Required: app_addr=0x0001238, cmd=001 for one cycle; resp_ready one cycle after valid data; resp_data matches.
REQ-040 Dirty miss, back-to-back:
- Stimulus: write pulse (addr 0x00A0008, data D) then read pulse (addr 0x00B0008) on the next cycle.
- Required: the write command and data are issued first with app_wdf_data=D; then the read; exactly one resp_ready.
REQ-041 Split write handshake:
- Stimulus: app_wdf_rdy=1 two cycles before app_rdy=1.
- Required: app_wdf_wren drops after its handshake; app_en is held until app_rdy; FSM returns to IDLE after the second handshake.
REQ-042 Overflow:
- Stimulus: calib=0; three request pulses.
- Required: first two queued; err_overflow=1 after the third; after calib rises, exactly two commands issue in order.
REQ-043 Reset mid-read:
- Stimulus: rstn low while in RD_WAIT.
- Required: all outputs at reset values; a late app_rd_data_valid after reset produces no resp_ready.
